// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------------------------
// branch_predict_unit
//
// ID-stage branch resolver with a PC-indexed table of saturating counters (BHT) for IF-stage
// direction prediction, plus branch / mispredict performance counters.
//
// Ports:
//   clk_i            clock, all state updates on rising edge
//   rst_i            synchronous active-high reset
//   if_pc_i          PC being fetched; indexes the BHT for pred_taken_o
//   pred_taken_o     MSB of the indexed BHT counter (combinational read)
//   id_valid_i       ID instruction valid
//   id_stall_i       ID held this cycle; blocks every state update
//   id_pc_i          PC of the ID instruction
//   opcode_i         ID opcode
//   funct3_i         ID funct3
//   rs1_data_i       forwarded rs1 value
//   rs2_data_i       forwarded rs2 value
//   imm_i            sign-extended B/J/I immediate
//   id_pred_taken_i  prediction made in IF for the ID instruction
//   branch_o         valid conditional branch with legal funct3
//   taken_o          resolved direction (1 for JAL/JALR)
//   flush_o          flush IF_ID and redirect fetch
//   redirect_pc_o    fetch PC when flush_o=1, fall-through otherwise
//   br_count_o       resolved conditional branches
//   mispred_count_o  flushes (mispredicted branches plus JAL/JALR flushes)
// ---------------------------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned PERF_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic [XLEN-1:0]   if_pc_i,
    output logic              pred_taken_o,

    input  logic              id_valid_i,
    input  logic              id_stall_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              id_pred_taken_i,

    output logic              branch_o,
    output logic              taken_o,
    output logic              flush_o,
    output logic [XLEN-1:0]   redirect_pc_o,

    output logic [PERF_W-1:0] br_count_o,
    output logic [PERF_W-1:0] mispred_count_o
);

    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

    // Counters reset to weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntInit = CNT_W'((1 << (CNT_W - 1)) - 1);

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    // -----------------------------------------------------------------------------------------
    // Address arithmetic (all modulo 2^XLEN)
    // -----------------------------------------------------------------------------------------
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] fall_pc;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;

    assign br_target   = id_pc_i + imm_i;
    assign fall_pc     = id_pc_i + XLEN'(4);
    assign jalr_sum    = rs1_data_i + imm_i;
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

    // -----------------------------------------------------------------------------------------
    // Condition evaluation
    // -----------------------------------------------------------------------------------------
    logic rs_eq;
    logic rs_lt;
    logic rs_ltu;
    logic cond_true;
    logic f3_legal;

    assign rs_eq  = (rs1_data_i == rs2_data_i);
    assign rs_lt  = ($signed(rs1_data_i) < $signed(rs2_data_i));
    assign rs_ltu = (rs1_data_i < rs2_data_i);

    always_comb begin
        cond_true = 1'b0;
        f3_legal  = 1'b1;
        case (funct3_i)
            3'b000:  cond_true = rs_eq;
            3'b001:  cond_true = ~rs_eq;
            3'b100:  cond_true = rs_lt;
            3'b101:  cond_true = ~rs_lt;
            3'b110:  cond_true = rs_ltu;
            3'b111:  cond_true = ~rs_ltu;
            default: f3_legal  = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Decode, resolve and redirect
    // -----------------------------------------------------------------------------------------
    logic is_branch;
    logic is_jal;
    logic is_jalr;

    assign is_branch = id_valid_i && (opcode_i == OpBranch) && f3_legal;
    assign is_jal    = id_valid_i && (opcode_i == OpJal);
    assign is_jalr   = id_valid_i && (opcode_i == OpJalr);

    always_comb begin
        branch_o      = 1'b0;
        taken_o       = 1'b0;
        flush_o       = 1'b0;
        redirect_pc_o = fall_pc;
        if (is_branch) begin
            branch_o = 1'b1;
            taken_o  = cond_true;
            // A not-taken mispredict redirects to fall-through, already the default.
            if (cond_true != id_pred_taken_i) begin
                flush_o = 1'b1;
                if (cond_true) begin
                    redirect_pc_o = br_target;
                end
            end
        end else if (is_jal) begin
            taken_o = 1'b1;
            if (!id_pred_taken_i) begin
                flush_o       = 1'b1;
                redirect_pc_o = br_target;
            end
        end else if (is_jalr) begin
            // No target prediction exists, so JALR always redirects.
            taken_o       = 1'b1;
            flush_o       = 1'b1;
            redirect_pc_o = jalr_target;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Branch history table
    // -----------------------------------------------------------------------------------------
    logic [CNT_W-1:0] bht_q [BHT_ENTRIES];
    logic [IdxW-1:0]  if_idx;
    logic [IdxW-1:0]  id_idx;
    logic [CNT_W-1:0] bht_cur;
    logic [CNT_W-1:0] bht_d;
    logic             bht_we;

    // Word-aligned PCs: drop the two low bits, take the next IdxW bits unhashed.
    assign if_idx = if_pc_i[IdxW+1:2];
    assign id_idx = id_pc_i[IdxW+1:2];

    // Read is the registered value, so a same-cycle update of this index is not bypassed.
    assign pred_taken_o = bht_q[if_idx][CNT_W-1];

    assign bht_cur = bht_q[id_idx];
    assign bht_we  = branch_o && !id_stall_i;

    always_comb begin
        bht_d = bht_cur;
        if (taken_o) begin
            if (bht_cur != CntMax) begin
                bht_d = bht_cur + CNT_W'(1);
            end
        end else begin
            if (bht_cur != '0) begin
                bht_d = bht_cur - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= CntInit;
            end
        end else if (bht_we) begin
            bht_q[id_idx] <= bht_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Performance counters (wrap silently)
    // -----------------------------------------------------------------------------------------
    logic [PERF_W-1:0] br_count_q;
    logic [PERF_W-1:0] br_count_d;
    logic [PERF_W-1:0] mispred_count_q;
    logic [PERF_W-1:0] mispred_count_d;

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (!id_stall_i) begin
            if (branch_o) begin
                br_count_d = br_count_q + PERF_W'(1);
            end
            if (flush_o) begin
                mispred_count_d = mispred_count_q + PERF_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count_o      = br_count_q;
    assign mispred_count_o = mispred_count_q;

    // Fetch-PC bits outside the index field carry no information for the table.
    logic unused_if_pc;
    assign unused_if_pc = ^{if_pc_i[XLEN-1:IdxW+2], if_pc_i[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        id_valid;
    logic        id_stall;
    logic [31:0] id_pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        id_pred_taken;
    logic        branch;
    logic        taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .if_pc_i         (if_pc),
        .pred_taken_o    (pred_taken),
        .id_valid_i      (id_valid),
        .id_stall_i      (id_stall),
        .id_pc_i         (id_pc),
        .opcode_i        (opcode),
        .funct3_i        (funct3),
        .rs1_data_i      (rs1_data),
        .rs2_data_i      (rs2_data),
        .imm_i           (imm),
        .id_pred_taken_i (id_pred_taken),
        .branch_o        (branch),
        .taken_o         (taken),
        .flush_o         (flush),
        .redirect_pc_o   (redirect_pc),
        .br_count_o      (br_count),
        .mispred_count_o (mispred_count)
    );

    typedef struct {
        string       name;
        logic        pred;
        logic        br;
        logic        tk;
        logic        fl;
        logic [31:0] rd;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input string n, input logic p, input logic b, input logic t,
                                input logic f, input logic [31:0] r, input logic [31:0] c,
                                input logic [31:0] m);
        exp_t e;
        e.name = n; e.pred = p; e.br = b; e.tk = t; e.fl = f; e.rd = r; e.bc = c; e.mc = m;
        return e;
    endfunction

    task automatic chk(input string n, input string f, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%h want=%h", n, f, act, want);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, one expectation per stimulus cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "pred",     32'(pred_taken),  32'(e.pred));
            chk(e.name, "branch",   32'(branch),      32'(e.br));
            chk(e.name, "taken",    32'(taken),       32'(e.tk));
            chk(e.name, "flush",    32'(flush),       32'(e.fl));
            chk(e.name, "redirect", redirect_pc,      e.rd);
            chk(e.name, "br_cnt",   br_count,         e.bc);
            chk(e.name, "mp_cnt",   mispred_count,    e.mc);
        end
    end

    task automatic cyc(input logic r, input logic v, input logic s, input logic [31:0] pc,
                       input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic pp,
                       input logic [31:0] ipc, input exp_t e);
        @(posedge clk);
        #1;
        rst = r; id_valid = v; id_stall = s; id_pc = pc; opcode = op; funct3 = f3;
        rs1_data = a; rs2_data = b; imm = im; id_pred_taken = pp; if_pc = ipc;
        sb.push_back(e);
    endtask

    task automatic idle(input logic r, input logic [31:0] ipc, input logic p,
                        input logic [31:0] c, input logic [31:0] m, input string n);
        cyc(r, 1'b0, 1'b0, 32'h0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 1'b0, ipc,
            mk(n, p, 1'b0, 1'b0, 1'b0, 32'h4, c, m));
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_stall = 1'b0; id_pc = '0; opcode = '0; funct3 = '0;
        rs1_data = '0; rs2_data = '0; imm = '0; id_pred_taken = 1'b0; if_pc = '0;
        repeat (2) @(posedge clk);

        idle(1'b1, 32'h0, 1'b0, 0, 0, "reset");
        for (int i = 0; i < 64; i++) begin
            idle(1'b0, 32'(i * 4), 1'b0, 0, 0, "sweep");
        end

        // BEQ taken, predicted not-taken
        cyc(0, 1, 0, 32'h100, OP_BR, 3'b000, 32'd5, 32'd5, 32'h20, 0, 32'h100,
            mk("beq", 0, 1, 1, 1, 32'h120, 0, 0));
        idle(0, 32'h100, 1'b1, 1, 1, "beq_after");

        // Signed vs unsigned compare
        cyc(0, 1, 0, 32'h204, OP_BR, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 32'h204,
            mk("blt", 0, 1, 1, 0, 32'h208, 1, 1));
        cyc(0, 1, 0, 32'h208, OP_BR, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 32'h204,
            mk("bltu", 1, 1, 0, 1, 32'h20C, 2, 1));
        idle(0, 32'h208, 1'b0, 3, 2, "bltu_after");

        // Saturation on entry 3
        cyc(0, 1, 0, 32'h10C, OP_BR, 3'b101, 32'd5, 32'd5, 32'h40, 1, 32'h10C,
            mk("bge0", 0, 1, 1, 0, 32'h110, 3, 2));
        cyc(0, 1, 0, 32'h10C, OP_BR, 3'b101, 32'd5, 32'd5, 32'h40, 1, 32'h10C,
            mk("bge1", 1, 1, 1, 0, 32'h110, 4, 2));
        cyc(0, 1, 0, 32'h10C, OP_BR, 3'b101, 32'd5, 32'd5, 32'h40, 1, 32'h10C,
            mk("bge2", 1, 1, 1, 0, 32'h110, 5, 2));
        cyc(0, 1, 0, 32'h10C, OP_BR, 3'b101, 32'd5, 32'd5, 32'h40, 1, 32'h10C,
            mk("bge3", 1, 1, 1, 0, 32'h110, 6, 2));
        cyc(0, 1, 0, 32'h10C, OP_BR, 3'b111, 32'd1, 32'd2, 32'h40, 1, 32'h10C,
            mk("bgeu_nt", 1, 1, 0, 1, 32'h110, 7, 2));
        cyc(0, 1, 0, 32'h10C, OP_BR, 3'b001, 32'd7, 32'd7, 32'h40, 0, 32'h10C,
            mk("bne_nt", 1, 1, 0, 0, 32'h110, 8, 3));
        idle(0, 32'h10C, 1'b0, 9, 3, "sat_after");

        // Jumps, illegal funct3, other opcode, invalid
        cyc(0, 1, 0, 32'h300, OP_JALR, 3'b000, 32'h1003, 32'h0, 32'h0, 0, 32'h300,
            mk("jalr", 1, 0, 1, 1, 32'h1002, 9, 3));
        cyc(0, 1, 0, 32'h400, OP_JAL, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 1, 32'h300,
            mk("jal_hit", 1, 0, 1, 0, 32'h404, 9, 4));
        cyc(0, 1, 0, 32'h400, OP_JAL, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF0, 0, 32'h300,
            mk("jal_miss", 1, 0, 1, 1, 32'h3F0, 9, 4));
        cyc(0, 1, 0, 32'h10C, OP_BR, 3'b010, 32'd5, 32'd5, 32'h40, 0, 32'h10C,
            mk("illegal", 0, 0, 0, 0, 32'h110, 9, 5));
        cyc(0, 1, 0, 32'h10C, OP_ALU, 3'b000, 32'd5, 32'd5, 32'h40, 0, 32'h10C,
            mk("alu", 0, 0, 0, 0, 32'h110, 9, 5));
        cyc(0, 0, 0, 32'h10C, OP_BR, 3'b000, 32'd5, 32'd5, 32'h40, 0, 32'h10C,
            mk("invalid", 0, 0, 0, 0, 32'h110, 9, 5));
        cyc(0, 1, 0, 32'hFFFF_FFF0, OP_BR, 3'b000, 32'd1, 32'd1, 32'h20, 0, 32'hFFFF_FFF0,
            mk("wrap", 0, 1, 1, 1, 32'h10, 9, 5));
        idle(0, 32'hFFFF_FFF0, 1'b1, 10, 6, "wrap_after");

        // Stall held three cycles, then released
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 32'h114, OP_BR, 3'b000, 32'd3, 32'd3, 32'h20, 1, 32'h114,
                mk("stall", 0, 1, 1, 0, 32'h118, 10, 6));
        end
        cyc(0, 1, 0, 32'h114, OP_BR, 3'b000, 32'd3, 32'd3, 32'h20, 1, 32'h114,
            mk("release", 0, 1, 1, 0, 32'h118, 10, 6));
        cyc(0, 1, 0, 32'h114, OP_BR, 3'b001, 32'd3, 32'd3, 32'h20, 1, 32'h114,
            mk("stall_bne", 1, 1, 0, 1, 32'h118, 11, 6));
        idle(0, 32'h114, 1'b0, 12, 7, "stall_after");

        // Reset concurrent with an update
        cyc(1, 1, 0, 32'h118, OP_BR, 3'b000, 32'd9, 32'd9, 32'h20, 0, 32'h114,
            mk("rst_upd", 0, 1, 1, 1, 32'h138, 12, 7));
        idle(0, 32'h118, 1'b0, 0, 0, "rst_e6");
        idle(0, 32'h100, 1'b0, 0, 0, "rst_e0");
        cyc(0, 1, 0, 32'h118, OP_BR, 3'b000, 32'd9, 32'd9, 32'h20, 1, 32'h118,
            mk("post_rst", 0, 1, 1, 0, 32'h11C, 0, 0));
        idle(0, 32'h118, 1'b1, 1, 0, "post_rst_after");

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d pending want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the ID-stage branch resolver.
- Resolves all six RV32I conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), plus JAL and JALR.
- Computes the redirect target and raises a flush only on misprediction.
- Holds a PC-indexed table of saturating counters (BHT) that the IF stage reads for taken/not-taken prediction, plus branch and mispredict performance counters.

Parameters:
- XLEN, 32, datapath and PC width.
- BHT_ENTRIES, 64, number of BHT counters; power of two, min 2.
- CNT_W, 2, width of each saturating counter; min 1.
- PERF_W, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- if_pc_i  in  XLEN  PC of the instruction being fetched.
- pred_taken_o  out  1  prediction for if_pc_i (combinational table read).
- id_valid_i  in  1  ID-stage instruction valid.
- id_stall_i  in  1  ID held this cycle; suppresses all state updates.
- id_pc_i  in  XLEN  PC of the ID instruction.
- opcode_i  in  7  ID opcode.
- funct3_i  in  3  ID funct3.
- rs1_data_i  in  XLEN  forwarded rs1 value.
- rs2_data_i  in  XLEN  forwarded rs2 value.
- imm_i  in  XLEN  sign-extended B/J/I immediate.
- id_pred_taken_i  in  1  prediction made in IF for this instruction, carried through IF_ID.
- branch_o  out  1  ID instruction is a valid conditional branch with legal funct3.
- taken_o  out  1  resolved direction.
- flush_o  out  1  flush IF_ID and redirect PC.
- redirect_pc_o  out  XLEN  PC to fetch when flush_o=1.
- br_count_o  out  PERF_W  resolved conditional branches.
- mispred_count_o  out  PERF_W  mispredicted conditional branches plus JAL/JALR flushes.

Behaviour:
- Reset (rst_i=1 at edge):
  - Every BHT entry = 2^(CNT_W-1)-1 (weakly not-taken; 01 for CNT_W=2; 0 for CNT_W=1).
  - Both perf counters = 0.
  - rst_i takes priority over any concurrent update.
  - Outputs are combinational and need no reset value. During and after reset, pred_taken_o=0 for every PC.
- Index: idx = pc[log2(BHT_ENTRIES)+1:2]. The PC bits are dropped, not hashed.
- Prediction: pred_taken_o = MSB of BHT[idx(if_pc_i)].
- Same-cycle read and update of the same idx: the read returns the pre-update value (no bypass).
- Decode (all outputs require id_valid_i=1; otherwise branch_o=taken_o=flush_o=0):
  - opcode 1100011 is a conditional branch. funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - funct3 010 and 011 are illegal: branch_o=0, taken_o=0, flush_o=0, no BHT update, no counting.
  - opcode 1101111 is JAL: taken_o=1, target = id_pc_i+imm_i.
  - opcode 1100111 is JALR: taken_o=1, target = (rs1_data_i+imm_i) with bit0 cleared.
  - Any other opcode: all outputs 0.
- Arithmetic: all adds are modulo 2^XLEN; wrap-around is silent.
- Branch target = id_pc_i+imm_i.
- Fall-through = id_pc_i+4.
- Flush rules, evaluated in the same cycle, zero latency from ID inputs:
  - Conditional branch: flush_o = taken_o XOR id_pred_taken_i. redirect_pc_o = taken_o ? target : fall-through.
  - JAL: flush_o = ~id_pred_taken_i, redirect_pc_o = target.
  - JALR: flush_o=1 always; no target prediction.
  - When flush_o=0, redirect_pc_o = fall-through (don't-care for the pipeline, but fixed for the bench).
- BHT update at the rising edge when branch_o=1 and id_stall_i=0:
  - If taken, the entry increments, saturating at 2^CNT_W-1.
  - If not taken, the entry decrements, saturating at 0.
  - JAL and JALR never update the BHT.
- Perf counters, at the edge when id_stall_i=0:
  - br_count_o increments when branch_o=1.
  - mispred_count_o increments when flush_o=1.
  - Both wrap from 2^PERF_W-1 to 0.
- Stall: while id_stall_i=1, combinational outputs still reflect inputs, but no state changes. One instruction held for N cycles updates exactly once, on the cycle its stall drops.
- Reset mid-operation discards any pending update in that cycle.

Test Plan:
- Reset, then sweep if_pc_i over all indices -> pred_taken_o=0 everywhere; both counters 0.
- BEQ at pc=0x100, rs1=rs2=5, imm=0x20, pred=0 -> taken_o=1, flush_o=1, redirect=0x120. Next cycle BHT[0] holds 10, and pred_taken_o=1 for if_pc=0x100.
- BLT vs BLTU with rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken. A pred=1 on the BLTU gives flush_o=1, redirect=pc+4.
- Four taken updates on one entry -> counter saturates at 11. Then one not-taken -> 10, and pred stays 1.
- JALR with rs1=0x1003, imm=0 -> flush_o=1, redirect=0x1002, BHT unchanged, mispred_count_o +1. funct3=010 -> all outputs 0, no count.
- Branch held 3 cycles with id_stall_i=1, then released -> exactly one BHT update and br_count_o +1. rst_i asserted concurrently with an update -> the update is lost and the entry returns to 01.
